// File: rtl/writeback_rr_arbiter_pkg.sv
// writeback_rr_arbiter_pkg
//   Shared types and widths for the execute-to-writeback arbiter.
//   w_msg_t : {pc, seq_num, waddr, wdata, wen, preg, ppreg}, one execute-unit writeback message.
//   sat_inc16 : saturating 16-bit increment used by the optional stall counters.
package writeback_rr_arbiter_pkg;

  localparam int unsigned P_NUM_PIPES      = 3;
  localparam int unsigned P_SEQ_NUM_BITS   = 5;
  localparam int unsigned P_PHYS_ADDR_BITS = 6;
  localparam int unsigned P_STALL_CNT_BITS = 16;

  typedef struct packed {
    logic [31:0]                 pc;
    logic [P_SEQ_NUM_BITS-1:0]   seq_num;
    logic [4:0]                  waddr;
    logic [31:0]                 wdata;
    logic                        wen;
    logic [P_PHYS_ADDR_BITS-1:0] preg;
    logic [P_PHYS_ADDR_BITS-1:0] ppreg;
  } w_msg_t;

  function automatic logic [P_STALL_CNT_BITS-1:0] sat_inc16(
    input logic [P_STALL_CNT_BITS-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/writeback_rr_arbiter_if.sv
// writeback_rr_arbiter_if
//   Bundles the N execute-side valid/ready/message channels and the single writeback channel.
//   x_val/x_msg : per-input request and message (driven by execute units)
//   x_rdy       : per-input grant (driven by the arbiter)
//   w_val/w_msg : writeback message out (driven by the arbiter)
//   w_rdy       : writeback ready (driven by writeback/commit)
//   modport master : the environment (execute units + writeback sink)
//   modport slave  : the arbiter
interface writeback_rr_arbiter_if
  import writeback_rr_arbiter_pkg::*;
#(
  parameter int unsigned p_num_pipes = P_NUM_PIPES
) ();

  logic   [p_num_pipes-1:0] x_val;
  logic   [p_num_pipes-1:0] x_rdy;
  w_msg_t [p_num_pipes-1:0] x_msg;
  logic                     w_val;
  logic                     w_rdy;
  w_msg_t                   w_msg;

  modport master (
    output x_val, x_msg, w_rdy,
    input  x_rdy, w_val, w_msg
  );

  modport slave (
    input  x_val, x_msg, w_rdy,
    output x_rdy, w_val, w_msg
  );

endinterface

// File: rtl/writeback_rr_arbiter_rr_arbiter.sv
// writeback_rr_arbiter_rr_arbiter
//   Round-robin arbiter with a registered priority pointer.
//   clk, rst : clock, synchronous active-high reset (pointer -> 0)
//   i_req    : per-requester request
//   i_en     : grant enable; when low no grant is issued and the pointer holds
//   o_gnt    : one-hot grant (all zero when !i_en or no request)
//   The pointer moves to just past the winner only when a grant is actually issued.
module writeback_rr_arbiter_rr_arbiter #(
  parameter int unsigned p_width = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [p_width-1:0] i_req,
  input  logic               i_en,
  output logic [p_width-1:0] o_gnt
);

  localparam int unsigned PtrW = (p_width > 1) ? $clog2(p_width) : 1;

  logic [PtrW-1:0] r_ptr;
  logic [PtrW-1:0] w_win;
  logic [PtrW-1:0] w_ptr_next;
  logic            w_any;

  // Scan ptr, ptr+1, ... modulo p_width; first requester found wins.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int unsigned k = 0; k < p_width; k++) begin
      if (!w_any && i_req[PtrW'((k + 32'(r_ptr)) % p_width)]) begin
        w_win = PtrW'((k + 32'(r_ptr)) % p_width);
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    o_gnt = '0;
    if (i_en && w_any) begin
      o_gnt[w_win] = 1'b1;
    end
  end

  assign w_ptr_next = (w_win == PtrW'(p_width - 1)) ? '0 : w_win + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_en && w_any) begin
      r_ptr <= w_ptr_next;
    end
  end

endmodule

// File: rtl/writeback_rr_arbiter.sv
// writeback_rr_arbiter
//   Merges p_num_pipes execute-unit outputs onto one writeback port through a
//   round-robin arbiter and a single output slot register (1-cycle latency,
//   1 msg/cycle while w_rdy is high).
//   clk, rst    : clock, synchronous active-high reset (slot dropped, pointer/counters cleared)
//   io_bus      : writeback_rr_arbiter_if.slave (x_val/x_rdy/x_msg in, w_val/w_rdy/w_msg out)
//   o_stall_cnt : per-input saturating stall-cycle counters, present only when
//                 X_W_ARB_STALL_CNT_EN is defined
//   Messages are forwarded unmodified, including wen=0 messages.
module writeback_rr_arbiter
  import writeback_rr_arbiter_pkg::*;
#(
  parameter int unsigned p_num_pipes = P_NUM_PIPES
) (
  input  logic clk,
  input  logic rst,
  writeback_rr_arbiter_if.slave io_bus
`ifdef X_W_ARB_STALL_CNT_EN
  ,
  output logic [p_num_pipes-1:0][P_STALL_CNT_BITS-1:0] o_stall_cnt
`endif
);

  logic                   r_val;
  w_msg_t                 r_msg;
  logic                   w_slot_free;
  logic [p_num_pipes-1:0] w_gnt;
  w_msg_t                 w_sel_msg;

  // The slot can take a new message if empty or if it drains this cycle.
  assign w_slot_free = !r_val || io_bus.w_rdy;

  writeback_rr_arbiter_rr_arbiter #(
    .p_width (p_num_pipes)
  ) u_rr (
    .clk   (clk),
    .rst   (rst),
    .i_req (io_bus.x_val),
    .i_en  (w_slot_free),
    .o_gnt (w_gnt)
  );

  // AND-OR mux; w_gnt is one-hot or zero.
  always_comb begin
    w_sel_msg = '0;
    for (int unsigned i = 0; i < p_num_pipes; i++) begin
      if (w_gnt[i]) begin
        w_sel_msg = w_msg_t'(w_sel_msg | io_bus.x_msg[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_val <= 1'b0;
    end else if (w_slot_free) begin
      r_val <= |w_gnt;
    end
  end

  // Payload needs no reset; it is only observed while r_val is set.
  always_ff @(posedge clk) begin
    if (|w_gnt) begin
      r_msg <= w_sel_msg;
    end
  end

  assign io_bus.x_rdy = w_gnt;
  assign io_bus.w_val = r_val;
  assign io_bus.w_msg = r_msg;

`ifdef X_W_ARB_STALL_CNT_EN
  logic [p_num_pipes-1:0][P_STALL_CNT_BITS-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < p_num_pipes; i++) begin
        if (io_bus.x_val[i] && !w_gnt[i]) begin
          r_stall_cnt[i] <= sat_inc16(r_stall_cnt[i]);
        end
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

`ifndef SYNTHESIS
  function automatic string linetrace();
    return $sformatf("%b/%b -> %b:%h", io_bus.x_val, io_bus.x_rdy, r_val, r_msg.seq_num);
  endfunction
`endif

endmodule
